// File: rtl/id_ex_stage_pkg.sv
// Shared types for the ID/EX boundary: decoder control bundle and select encodings.
package id_ex_stage_pkg;

    typedef enum logic [2:0] {
        ALU_BRANCH = 3'd1,
        ALU_R      = 3'd2,
        ALU_ADDI   = 3'd3,
        ALU_SLTIU  = 3'd4,
        ALU_ORI    = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        MTR_ALU = 2'd0,
        MTR_MEM = 2'd1,
        MTR_PC4 = 2'd2
    } mem_to_reg_e;

    typedef enum logic [1:0] {
        RDST_RT = 2'd0,
        RDST_RD = 2'd1,
        RDST_RA = 2'd2
    } reg_dst_e;

    // Field order matches the decoder output order; zeroing the whole struct makes a bubble.
    typedef struct packed {
        logic       reg_write;
        logic [2:0] alu_op;
        logic       alu_src;
        logic [1:0] reg_dst;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_to_reg;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: a load in EX whose rt feeds the instruction in ID.
module id_ex_stage_hazard_detect
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic              ex_mem_read,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [1:0]        id_reg_dst,
    input  logic              id_branch,
    input  logic              id_mem_write,
    input  logic              flush,
    output logic              hazard_c,
    output logic              stall_c
);

    logic uses_rt;
    logic rs_match;
    logic rt_match;

    // rt is a source only for R-type, branches and stores.
    assign uses_rt  = (id_reg_dst == 2'(RDST_RD)) | id_branch | id_mem_write;
    assign rs_match = (ex_rt == id_rs);
    assign rt_match = uses_rt & (ex_rt == id_rt);

    assign hazard_c = ex_mem_read & ex_valid & (ex_rt != '0) & (rs_match | rt_match);
    // A flushed instruction is being killed, so it never needs to wait.
    assign stall_c  = hazard_c & ~flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, hold and bubble counter.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_reg_write_i,
    input  logic [2:0]        id_alu_op_i,
    input  logic              id_alu_src_i,
    input  logic [1:0]        id_reg_dst_i,
    input  logic              id_branch_i,
    input  logic              id_mem_read_i,
    input  logic              id_mem_write_i,
    input  logic [1:0]        id_mem_to_reg_i,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic [DATA_W-1:0] id_pc4_i,
    input  logic              flush_i,
    input  logic              hold_i,
    output logic              stall_o,
    output logic              ex_reg_write_o,
    output logic [2:0]        ex_alu_op_o,
    output logic              ex_alu_src_o,
    output logic [1:0]        ex_reg_dst_o,
    output logic              ex_branch_o,
    output logic              ex_mem_read_o,
    output logic              ex_mem_write_o,
    output logic [1:0]        ex_mem_to_reg_o,
    output logic [DATA_W-1:0] ex_rs_data_o,
    output logic [DATA_W-1:0] ex_rt_data_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [REG_AW-1:0] ex_rs_o,
    output logic [REG_AW-1:0] ex_rt_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic [DATA_W-1:0] ex_pc4_o,
    output logic              ex_valid_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    ctrl_t id_ctrl;
    ctrl_t ex_ctrl;
    logic  hazard;
    logic  stall;

    always_comb begin
        id_ctrl            = CTRL_NOP;
        id_ctrl.reg_write  = id_reg_write_i;
        id_ctrl.alu_op     = id_alu_op_i;
        id_ctrl.alu_src    = id_alu_src_i;
        id_ctrl.reg_dst    = id_reg_dst_i;
        id_ctrl.branch     = id_branch_i;
        id_ctrl.mem_read   = id_mem_read_i;
        id_ctrl.mem_write  = id_mem_write_i;
        id_ctrl.mem_to_reg = id_mem_to_reg_i;
    end

    id_ex_stage_hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .ex_mem_read  (ex_ctrl.mem_read),
        .ex_valid     (ex_valid_o),
        .ex_rt        (ex_rt_o),
        .id_rs        (id_rs_i),
        .id_rt        (id_rt_i),
        .id_reg_dst   (id_reg_dst_i),
        .id_branch    (id_branch_i),
        .id_mem_write (id_mem_write_i),
        .flush        (flush_i),
        .hazard_c     (hazard),
        .stall_c      (stall)
    );

    assign stall_o = stall;

    // Priority: flush, hold, load-use bubble, normal capture. Data follows the inputs unless held.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_ctrl      <= CTRL_NOP;
            ex_rs_data_o <= '0;
            ex_rt_data_o <= '0;
            ex_imm_o     <= '0;
            ex_rs_o      <= '0;
            ex_rt_o      <= '0;
            ex_rd_o      <= '0;
            ex_pc4_o     <= '0;
            ex_valid_o   <= 1'b0;
            bubble_cnt_o <= '0;
        end else if (flush_i || !hold_i) begin
            ex_rs_data_o <= id_rs_data_i;
            ex_rt_data_o <= id_rt_data_i;
            ex_imm_o     <= id_imm_i;
            ex_rs_o      <= id_rs_i;
            ex_rt_o      <= id_rt_i;
            ex_rd_o      <= id_rd_i;
            ex_pc4_o     <= id_pc4_i;
            if (flush_i) begin
                ex_ctrl    <= CTRL_NOP;
                ex_valid_o <= 1'b0;
            end else if (hazard) begin
                ex_ctrl    <= CTRL_NOP;
                ex_valid_o <= 1'b0;
                if (bubble_cnt_o != '1) begin
                    bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
                end
            end else begin
                ex_ctrl    <= id_ctrl;
                ex_valid_o <= 1'b1;
            end
        end
    end

    assign ex_reg_write_o  = ex_ctrl.reg_write;
    assign ex_alu_op_o     = ex_ctrl.alu_op;
    assign ex_alu_src_o    = ex_ctrl.alu_src;
    assign ex_reg_dst_o    = ex_ctrl.reg_dst;
    assign ex_branch_o     = ex_ctrl.branch;
    assign ex_mem_read_o   = ex_ctrl.mem_read;
    assign ex_mem_write_o  = ex_ctrl.mem_write;
    assign ex_mem_to_reg_o = ex_ctrl.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reference model feeds a scoreboard queue checked one edge later.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    // Narrow counter so saturation is reachable in a short run.
    localparam int unsigned CW = 5;

    typedef struct packed {
        ctrl_t          c;
        logic [DW-1:0]  rs_data;
        logic [DW-1:0]  rt_data;
        logic [DW-1:0]  imm;
        logic [DW-1:0]  pc4;
        logic [AW-1:0]  rs;
        logic [AW-1:0]  rt;
        logic [AW-1:0]  rd;
    } stim_t;

    typedef struct packed {
        stim_t         ex;
        logic          valid;
        logic [CW-1:0] cnt;
        logic          check_data;
    } exp_t;

    localparam ctrl_t CT_ADDI = '{reg_write: 1'b1, alu_op: ALU_ADDI, alu_src: 1'b1, reg_dst: RDST_RT,
                                  branch: 1'b0, mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: MTR_ALU};
    localparam ctrl_t CT_LW   = '{reg_write: 1'b1, alu_op: ALU_ADDI, alu_src: 1'b1, reg_dst: RDST_RT,
                                  branch: 1'b0, mem_read: 1'b1, mem_write: 1'b0, mem_to_reg: MTR_MEM};
    localparam ctrl_t CT_R    = '{reg_write: 1'b1, alu_op: ALU_R, alu_src: 1'b0, reg_dst: RDST_RD,
                                  branch: 1'b0, mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: MTR_ALU};
    localparam ctrl_t CT_SW   = '{reg_write: 1'b0, alu_op: ALU_ADDI, alu_src: 1'b1, reg_dst: RDST_RT,
                                  branch: 1'b0, mem_read: 1'b0, mem_write: 1'b1, mem_to_reg: MTR_ALU};
    localparam ctrl_t CT_BEQ  = '{reg_write: 1'b0, alu_op: ALU_BRANCH, alu_src: 1'b0, reg_dst: RDST_RT,
                                  branch: 1'b1, mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: MTR_ALU};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_reg_write, id_alu_src, id_branch, id_mem_read, id_mem_write;
    logic [2:0]    id_alu_op;
    logic [1:0]    id_reg_dst, id_mem_to_reg;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm, id_pc4;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic          flush, hold;
    logic          stall;
    logic          ex_reg_write, ex_alu_src, ex_branch, ex_mem_read, ex_mem_write, ex_valid;
    logic [2:0]    ex_alu_op;
    logic [1:0]    ex_reg_dst, ex_mem_to_reg;
    logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
    logic [AW-1:0] ex_rs, ex_rt, ex_rd;
    logic [CW-1:0] bubble_cnt;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    stim_t         m_ex;
    logic          m_valid;
    logic          m_known;
    logic [CW-1:0] m_cnt;

    id_ex_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
        .clk_i           (clk),
        .rst_i           (rst_n),
        .id_reg_write_i  (id_reg_write),
        .id_alu_op_i     (id_alu_op),
        .id_alu_src_i    (id_alu_src),
        .id_reg_dst_i    (id_reg_dst),
        .id_branch_i     (id_branch),
        .id_mem_read_i   (id_mem_read),
        .id_mem_write_i  (id_mem_write),
        .id_mem_to_reg_i (id_mem_to_reg),
        .id_rs_data_i    (id_rs_data),
        .id_rt_data_i    (id_rt_data),
        .id_imm_i        (id_imm),
        .id_rs_i         (id_rs),
        .id_rt_i         (id_rt),
        .id_rd_i         (id_rd),
        .id_pc4_i        (id_pc4),
        .flush_i         (flush),
        .hold_i          (hold),
        .stall_o         (stall),
        .ex_reg_write_o  (ex_reg_write),
        .ex_alu_op_o     (ex_alu_op),
        .ex_alu_src_o    (ex_alu_src),
        .ex_reg_dst_o    (ex_reg_dst),
        .ex_branch_o     (ex_branch),
        .ex_mem_read_o   (ex_mem_read),
        .ex_mem_write_o  (ex_mem_write),
        .ex_mem_to_reg_o (ex_mem_to_reg),
        .ex_rs_data_o    (ex_rs_data),
        .ex_rt_data_o    (ex_rt_data),
        .ex_imm_o        (ex_imm),
        .ex_rs_o         (ex_rs),
        .ex_rt_o         (ex_rt),
        .ex_rd_o         (ex_rd),
        .ex_pc4_o        (ex_pc4),
        .ex_valid_o      (ex_valid),
        .bubble_cnt_o    (bubble_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic stim_t mk(input ctrl_t c, input logic [AW-1:0] rs,
                                 input logic [AW-1:0] rt, input logic [AW-1:0] rd);
        stim_t s;
        s.c       = c;
        s.rs_data = $urandom;
        s.rt_data = $urandom;
        s.imm     = $urandom;
        s.pc4     = {$urandom_range(0, 1023), 2'b00};
        s.rs      = rs;
        s.rt      = rt;
        s.rd      = rd;
        return s;
    endfunction

    function automatic logic model_hazard(input stim_t s);
        logic uses_rt;
        uses_rt = (s.c.reg_dst == 2'd1) | s.c.branch | s.c.mem_write;
        return m_ex.c.mem_read & m_valid & (m_ex.rt != '0)
               & ((m_ex.rt == s.rs) | (uses_rt & (m_ex.rt == s.rt)));
    endfunction

    function automatic ctrl_t obs_ctrl();
        return {ex_reg_write, ex_alu_op, ex_alu_src, ex_reg_dst, ex_branch,
                ex_mem_read, ex_mem_write, ex_mem_to_reg};
    endfunction

    task automatic drive(input stim_t s, input logic fl, input logic hd);
        id_reg_write  = s.c.reg_write;
        id_alu_op     = s.c.alu_op;
        id_alu_src    = s.c.alu_src;
        id_reg_dst    = s.c.reg_dst;
        id_branch     = s.c.branch;
        id_mem_read   = s.c.mem_read;
        id_mem_write  = s.c.mem_write;
        id_mem_to_reg = s.c.mem_to_reg;
        id_rs_data    = s.rs_data;
        id_rt_data    = s.rt_data;
        id_imm        = s.imm;
        id_pc4        = s.pc4;
        id_rs         = s.rs;
        id_rt         = s.rt;
        id_rd         = s.rd;
        flush         = fl;
        hold          = hd;
    endtask

    task automatic model_reset();
        m_ex    = '0;
        m_valid = 1'b0;
        m_known = 1'b1;
        m_cnt   = '0;
        sb.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctrl"},  32'(obs_ctrl()), 32'd0);
        chk({tag, "_valid"}, 32'(ex_valid), 32'd0);
        chk({tag, "_cnt"},   32'(bubble_cnt), 32'd0);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_data"},  ex_rs_data | ex_rt_data | ex_imm | ex_pc4 | 32'({ex_rs, ex_rt, ex_rd}), 32'd0);
    endtask

    // Drive one ID instruction at the falling edge, check stall, predict EX, check after the rising edge.
    task automatic step(input string tag, input stim_t s, input logic fl, input logic hd);
        logic hz;
        exp_t e;
        drive(s, fl, hd);
        #1;
        hz = model_hazard(s);
        chk({tag, "_stall"}, 32'(stall), 32'(hz & ~fl));
        if (fl) begin
            m_ex = s; m_ex.c = CTRL_NOP; m_valid = 1'b0; m_known = 1'b1;
        end else if (!hd) begin
            if (hz) begin
                m_ex = s; m_ex.c = CTRL_NOP; m_valid = 1'b0; m_known = 1'b0;
                if (m_cnt != '1) m_cnt = m_cnt + CW'(1);
            end else begin
                m_ex = s; m_valid = 1'b1; m_known = 1'b1;
            end
        end
        e.ex = m_ex; e.valid = m_valid; e.cnt = m_cnt; e.check_data = m_known;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, "_ctrl"},  32'(obs_ctrl()), 32'(e.ex.c));
        chk({tag, "_valid"}, 32'(ex_valid), 32'(e.valid));
        chk({tag, "_cnt"},   32'(bubble_cnt), 32'(e.cnt));
        if (e.check_data) begin
            chk({tag, "_rsd"}, ex_rs_data, e.ex.rs_data);
            chk({tag, "_rtd"}, ex_rt_data, e.ex.rt_data);
            chk({tag, "_imm"}, ex_imm, e.ex.imm);
            chk({tag, "_pc4"}, ex_pc4, e.ex.pc4);
            chk({tag, "_regs"}, 32'({ex_rs, ex_rt, ex_rd}), 32'({e.ex.rs, e.ex.rt, e.ex.rd}));
        end
        @(negedge clk);
    endtask

    initial begin
        stim_t s;
        rst_n = 1'b0;
        drive('0, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all_zero("por");
        rst_n = 1'b1;

        // Plain ADDI capture
        s = mk(CT_ADDI, 5'd1, 5'd2, 5'd0);
        s.rs_data = 32'h1234_5678; s.imm = 32'h0000_FFFF; s.pc4 = 32'h40;
        step("addi", s, 1'b0, 1'b0);

        // Load-use: one bubble, then the R-type goes through
        step("lw8", mk(CT_LW, 5'd2, 5'd8, 5'd0), 1'b0, 1'b0);
        s = mk(CT_R, 5'd8, 5'd3, 5'd4);
        step("lu_bubble", s, 1'b0, 1'b0);
        step("lu_issue", s, 1'b0, 1'b0);

        // No false hazards: $0 target, and ADDI not reading rt
        step("lw0", mk(CT_LW, 5'd2, 5'd0, 5'd0), 1'b0, 1'b0);
        step("use0", mk(CT_R, 5'd0, 5'd0, 5'd5), 1'b0, 1'b0);
        step("lw9", mk(CT_LW, 5'd2, 5'd9, 5'd0), 1'b0, 1'b0);
        step("addi_rt9", mk(CT_ADDI, 5'd3, 5'd9, 5'd0), 1'b0, 1'b0);

        // rt dependence through a store and a branch
        step("lw9b", mk(CT_LW, 5'd2, 5'd9, 5'd0), 1'b0, 1'b0);
        s = mk(CT_SW, 5'd3, 5'd9, 5'd0);
        step("sw_bubble", s, 1'b0, 1'b0);
        step("sw_issue", s, 1'b0, 1'b0);
        step("lw11", mk(CT_LW, 5'd2, 5'd11, 5'd0), 1'b0, 1'b0);
        s = mk(CT_BEQ, 5'd4, 5'd11, 5'd0);
        step("beq_bubble", s, 1'b0, 1'b0);
        step("beq_issue", s, 1'b0, 1'b0);

        // Back-to-back loads, each checked against its follower
        step("bb_lw8", mk(CT_LW, 5'd2, 5'd8, 5'd0), 1'b0, 1'b0);
        s = mk(CT_LW, 5'd8, 5'd9, 5'd0);
        step("bb_bubble1", s, 1'b0, 1'b0);
        step("bb_lw9", s, 1'b0, 1'b0);
        s = mk(CT_R, 5'd9, 5'd1, 5'd6);
        step("bb_bubble2", s, 1'b0, 1'b0);
        step("bb_r", s, 1'b0, 1'b0);

        // Flush beats a pending hazard
        step("fl_lw8", mk(CT_LW, 5'd2, 5'd8, 5'd0), 1'b0, 1'b0);
        step("fl_kill", mk(CT_R, 5'd8, 5'd1, 5'd2), 1'b1, 1'b0);

        // Hold freezes EX with changing inputs, then a held hazard still stalls
        step("hd_addi", mk(CT_ADDI, 5'd1, 5'd7, 5'd0), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("hold", mk(CT_R, 5'(i + 1), 5'(i + 2), 5'(i + 3)), 1'b0, 1'b1);
        end
        step("hd_lw8", mk(CT_LW, 5'd2, 5'd8, 5'd0), 1'b0, 1'b0);
        s = mk(CT_R, 5'd8, 5'd1, 5'd2);
        step("hd_hz", s, 1'b0, 1'b1);
        step("hd_bubble", s, 1'b0, 1'b0);
        step("hd_issue", s, 1'b0, 1'b0);

        // Drive the counter into saturation and beyond
        for (int i = 0; i < 34; i++) begin
            step("sat_lw", mk(CT_LW, 5'd2, 5'd10, 5'd0), 1'b0, 1'b0);
            step("sat_bub", mk(CT_R, 5'd10, 5'd1, 5'd2), 1'b0, 1'b0);
        end
        chk("sat_final", 32'(bubble_cnt), 32'h1F);

        // Asynchronous reset while a stall is being requested
        step("rs_lw8", mk(CT_LW, 5'd2, 5'd8, 5'd0), 1'b0, 1'b0);
        drive(mk(CT_R, 5'd8, 5'd1, 5'd2), 1'b0, 1'b0);
        #1;
        chk("rs_pre_stall", 32'(stall), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("rs_mid");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", mk(CT_ADDI, 5'd4, 5'd5, 5'd0), 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline boundary of the pipelined MIPS core; sits directly downstream of the instruction decoder.
- Registers the decoder's control bundle together with register-file operands, immediate, register addresses and PC+4 for the EX stage.
- Contains the load-use hazard detector; on a hazard it stalls PC and IF/ID and inserts a bubble.
- Honours branch flush and external hold, and keeps a saturating bubble counter.

Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register address width
- CNT_W, 16, bubble counter width

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-low reset
- id_reg_write_i  in  1  decoder RegWrite
- id_alu_op_i  in  3  decoder ALU_op
- id_alu_src_i  in  1  decoder ALUSrc
- id_reg_dst_i  in  2  decoder RegDst
- id_branch_i  in  1  decoder Branch
- id_mem_read_i  in  1  decoder MemRead
- id_mem_write_i  in  1  decoder MemWrite
- id_mem_to_reg_i  in  2  decoder MemtoReg
- id_rs_data_i, id_rt_data_i  in  DATA_W  register-file read data
- id_imm_i  in  DATA_W  extended immediate
- id_rs_i, id_rt_i, id_rd_i  in  REG_AW  instruction register fields
- id_pc4_i  in  DATA_W  PC+4 of ID instruction
- flush_i  in  1  branch taken, kill ID instruction
- hold_i  in  1  global freeze (e.g. memory wait)
- stall_o  out  1  hold PC and IF/ID this cycle (combinational)
- ex_* outputs  out  same widths as the id_* inputs  registered copies of all id_* signals
- ex_valid_o  out  1  ex_* holds a real instruction
- bubble_cnt_o  out  CNT_W  bubbles inserted since reset

Behaviour:
- Reset (rst_i low, asynchronous):
  - All ex_* outputs, ex_valid_o and bubble_cnt_o are 0.
  - stall_o is 0 because ex_mem_read is 0.
- Hazard detection (combinational):
  - hazard = ex_mem_read_o & ex_valid_o & (ex_rt_o != 0) & ((ex_rt_o == id_rs_i) | (uses_rt & ex_rt_o == id_rt_i)).
  - uses_rt = (id_reg_dst_i == 1) | id_branch_i | id_mem_write_i.
  - stall_o = hazard & ~flush_i. Flush overrides, because the instruction is being killed.
- Register update at each rising edge, in priority order:
  1. flush_i = 1: all control fields zeroed (reg_write, branch, mem_read, mem_write, mem_to_reg, alu_op, alu_src, reg_dst). ex_valid_o = 0. Data fields are don't-care and are loaded from the inputs.
  2. hold_i = 1: every register keeps its value; bubble_cnt_o is unchanged; stall_o is still driven as computed.
  3. hazard = 1: bubble. Control fields and ex_valid_o are zeroed exactly as for flush. bubble_cnt_o increments, saturating at all-ones.
  4. Otherwise: all id_* inputs are captured into ex_* and ex_valid_o = 1.
- Latency: exactly one cycle from ID to EX. A load-use pair costs exactly one bubble; the second evaluation sees ex_mem_read = 0 and stall_o drops.
- Register $0: a load to $0 never stalls.
- Back-to-back loads: each is checked independently against the instruction that follows it.
- Flush and hazard in the same cycle: flush wins, stall_o = 0, the counter does not increment.
- Reset mid-stall: stall_o deasserts immediately (asynchronous path through the cleared registers).
- Counter at all-ones stays there; it wraps only on reset.

Decomposition:
- Shared package holds:
  - ALU_op encodings: R = 2, ADDI = 3, SLTIU = 4, ORI = 7, BRANCH = 1.
  - MemtoReg and RegDst select encodings.
  - A typedef for the control bundle, so flush/bubble zeroing is one assignment.
- One sub-module: hazard_detect (pure combinational hazard/stall logic), so it can be reused by a future forwarding unit.

Test Plan:
1. Reset: assert rst_i low mid-cycle with registers loaded -> all ex_* = 0, ex_valid_o = 0, bubble_cnt_o = 0 immediately, with no clock edge.
2. Plain capture: ADDI controls (alu_op 3, alu_src 1, reg_write 1), rs_data 0x12345678, imm 0x0000FFFF, pc4 0x40 -> next edge ex_* match the inputs, ex_valid_o = 1, stall_o = 0.
3. Load-use stall:
   - Stimulus: LW with rt = 8, followed by R-type with rs = 8.
   - Cycle after the LW is captured: stall_o = 1.
   - Next edge: bubble (all ex controls 0, ex_valid_o = 0), bubble_cnt_o = 1.
   - Following edge: the R-type is captured and stall_o = 0.
4. No false hazard:
   - LW rt = 0 followed by a user with rs = 0 -> stall_o = 0.
   - LW rt = 9 followed by ADDI with rt = 9 (uses_rt = 0) -> stall_o = 0.
5. Flush priority: hazard condition present and flush_i = 1 -> stall_o = 0, next edge all controls 0, ex_valid_o = 0, bubble_cnt_o unchanged.
6. Hold and saturation:
   - hold_i = 1 for 3 cycles with changing inputs -> ex_* frozen.
   - Preload the counter to 0xFFFF via repeated bubbles, then one more hazard -> bubble_cnt_o stays 0xFFFF.
